// File: rtl/int_arbiter.sv
// Interrupt arbiter: edge-detects four device lines, latches pending events and
// presents one fixed-priority grant at a time to the CPU on Ireq/gntInt.
module int_arbiter #(
  parameter int unsigned HOLDOFF = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  irq_in,
  input  logic [31:0] int_en,
  input  logic        Iack,
  output logic        Ireq,
  output logic [3:0]  gntInt,
  output logic [3:0]  pending_o
);

  localparam int unsigned N_SRC = 4;
  localparam int unsigned CNT_W = 4;

  generate
    if (HOLDOFF < 1 || HOLDOFF > 15) begin : g_bad_holdoff
      $error("int_arbiter: HOLDOFF must be in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [N_SRC-1:0]   irq_prev_q, irq_prev_d;
  logic [N_SRC-1:0]   pending_q, pending_d;
  logic [N_SRC-1:0]   gnt_q, gnt_d;
  logic               ireq_q, ireq_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [N_SRC-1:0]   rise;
  logic [N_SRC-1:0]   elig;
  logic [N_SRC-1:0]   first_elig;
  logic [N_SRC-1:0]   clr;

  // Only the global enable and the four source masks matter.
  logic unused_en;
  assign unused_en = ^int_en[31:5];

  assign rise       = irq_in & ~irq_prev_q;
  assign elig       = pending_q & int_en[4:1] & {N_SRC{int_en[0]}};
  assign first_elig = elig & (~elig + N_SRC'(1));

  // Next-state, grant and pending update; a rise outranks a same-cycle clear.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ireq_d     = ireq_q;
    cnt_d      = cnt_q;
    clr        = '0;
    irq_prev_d = irq_in;
    unique case (state_q)
      S_IDLE: begin
        if (elig != '0) begin
          gnt_d   = first_elig;
          ireq_d  = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (Iack) begin
          clr     = gnt_q;
          ireq_d  = 1'b0;
          gnt_d   = '0;
          cnt_d   = CNT_W'(HOLDOFF - 1);
          state_d = S_HOLD;
        end else if ((elig & gnt_q) == '0) begin
          ireq_d  = 1'b0;
          gnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        ireq_d  = 1'b0;
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    pending_d = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      irq_prev_q <= '0;
      pending_q  <= '0;
      gnt_q      <= '0;
      ireq_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= irq_prev_d;
      pending_q  <= pending_d;
      gnt_q      <= gnt_d;
      ireq_q     <= ireq_d;
      cnt_q      <= cnt_d;
    end
  end

  assign Ireq      = ireq_q;
  assign gntInt    = gnt_q;
  assign pending_o = pending_q;

endmodule

// File: tb/tb_int_arbiter.sv
// Self-checking bench for int_arbiter: directed vector table, async reset
// sequence and randomized traffic against a cycle-count reference model.
module tb_int_arbiter;

  localparam int HOLDOFF = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_in;
  logic [31:0] int_en;
  logic        Iack;
  logic        Ireq;
  logic [3:0]  gntInt;
  logic [3:0]  pending_o;

  int_arbiter #(.HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .int_en(int_en), .Iack(Iack),
    .Ireq(Ireq), .gntInt(gntInt), .pending_o(pending_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pending set, the source currently requested (-1 = none)
  // and the earliest edge index at which a new request may be raised.
  logic [3:0] m_pend;
  logic [3:0] m_prev;
  int         m_src;
  int         m_earliest;
  int         cyc;

  typedef struct {
    logic [3:0]  irq;
    logic [31:0] en;
    logic        ack;
    logic        ireq;
    logic [3:0]  gnt;
    logic [3:0]  pend;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_prev = '0; m_src = -1; m_earliest = 0; cyc = 0;
  endtask

  task automatic model_edge(input logic [3:0] irq, input logic [31:0] en, input logic ack);
    logic [3:0] rise;
    logic [3:0] elig;
    bit found;
    rise = irq & ~m_prev;
    elig = m_pend & en[4:1] & {4{en[0]}};
    if (m_src >= 0) begin
      if (ack) begin
        m_pend[m_src] = 1'b0;
        m_src = -1;
        m_earliest = cyc + HOLDOFF + 1;
      end else if (!elig[m_src]) begin
        m_src = -1;
        m_earliest = cyc + 1;
      end
    end else if (cyc >= m_earliest) begin
      found = 0;
      for (int i = 0; i < 4; i++) begin
        if (elig[i] && !found) begin
          m_src = i;
          found = 1;
        end
      end
    end
    m_pend = m_pend | rise;
    m_prev = irq;
    cyc++;
  endtask

  function automatic logic [3:0] model_gnt();
    return (m_src >= 0) ? 4'(1 << m_src) : 4'b0000;
  endfunction

  // One clock: drive at negedge, advance model at posedge, compare at negedge.
  task automatic step(input logic [3:0] irq, input logic [31:0] en, input logic ack);
    irq_in = irq; int_en = en; Iack = ack;
    @(posedge clk);
    model_edge(irq, en, ack);
    @(negedge clk);
    check("model_ireq", 32'(Ireq), 32'(m_src >= 0));
    check("model_gnt", 32'(gntInt), 32'(model_gnt()));
    check("model_pend", 32'(pending_o), 32'(m_pend));
  endtask

  task automatic add(input logic [3:0] irq, input logic [31:0] en, input logic ack,
                     input logic ireq, input logic [3:0] gnt, input logic [3:0] pend);
    vec_t v;
    v.irq = irq; v.en = en; v.ack = ack; v.ireq = ireq; v.gnt = gnt; v.pend = pend;
    vecs.push_back(v);
  endtask

  initial begin
    int n_req;
    logic prev_ireq;
    logic [3:0] irq_r;
    logic [31:0] en_r;

    // single event, holdoff, priority without preemption
    add(4'b0000, 32'h1F, 0, 0, 4'b0000, 4'b0000);
    add(4'b0100, 32'h1F, 0, 0, 4'b0000, 4'b0100);
    add(4'b0100, 32'h1F, 0, 1, 4'b0100, 4'b0100);
    add(4'b0100, 32'h1F, 1, 0, 4'b0000, 4'b0000);
    add(4'b0000, 32'h1F, 1, 0, 4'b0000, 4'b0000);
    add(4'b1000, 32'h1F, 0, 0, 4'b0000, 4'b1000);
    add(4'b1000, 32'h1F, 0, 1, 4'b1000, 4'b1000);
    add(4'b1001, 32'h1F, 0, 1, 4'b1000, 4'b1001);
    add(4'b1001, 32'h1F, 0, 1, 4'b1000, 4'b1001);
    add(4'b1001, 32'h1F, 1, 0, 4'b0000, 4'b0001);
    add(4'b1001, 32'h1F, 0, 0, 4'b0000, 4'b0001);
    add(4'b1001, 32'h1F, 0, 0, 4'b0000, 4'b0001);
    add(4'b1001, 32'h1F, 0, 1, 4'b0001, 4'b0001);
    add(4'b1001, 32'h1F, 1, 0, 4'b0000, 4'b0000);
    add(4'b0000, 32'h1F, 1, 0, 4'b0000, 4'b0000);
    add(4'b0000, 32'h1F, 0, 0, 4'b0000, 4'b0000);
    // masking, spurious ack in idle, withdrawal on global disable
    add(4'b1111, 32'h11, 0, 0, 4'b0000, 4'b1111);
    add(4'b1111, 32'h11, 0, 1, 4'b1000, 4'b1111);
    add(4'b1111, 32'h11, 1, 0, 4'b0000, 4'b0111);
    add(4'b1111, 32'h11, 0, 0, 4'b0000, 4'b0111);
    add(4'b1111, 32'h11, 0, 0, 4'b0000, 4'b0111);
    add(4'b1111, 32'h11, 1, 0, 4'b0000, 4'b0111);
    add(4'b1111, 32'h1F, 0, 1, 4'b0001, 4'b0111);
    add(4'b1111, 32'h1E, 0, 0, 4'b0000, 4'b0111);
    add(4'b1111, 32'h1E, 0, 0, 4'b0000, 4'b0111);
    add(4'b1111, 32'h1F, 0, 1, 4'b0001, 4'b0111);
    // rise on source 1 colliding with its own ack
    add(4'b1111, 32'h1F, 1, 0, 4'b0000, 4'b0110);
    add(4'b1111, 32'h1F, 0, 0, 4'b0000, 4'b0110);
    add(4'b1111, 32'h1F, 0, 0, 4'b0000, 4'b0110);
    add(4'b1111, 32'h1F, 0, 1, 4'b0010, 4'b0110);
    add(4'b1101, 32'h1F, 0, 1, 4'b0010, 4'b0110);
    add(4'b1111, 32'h1F, 1, 0, 4'b0000, 4'b0110);
    add(4'b1111, 32'h1F, 0, 0, 4'b0000, 4'b0110);
    add(4'b1111, 32'h1F, 0, 0, 4'b0000, 4'b0110);
    add(4'b1111, 32'h1F, 0, 1, 4'b0010, 4'b0110);
    add(4'b1111, 32'h1F, 1, 0, 4'b0000, 4'b0100);
    add(4'b1111, 32'h1F, 0, 0, 4'b0000, 4'b0100);
    add(4'b1111, 32'h1F, 0, 0, 4'b0000, 4'b0100);
    add(4'b1111, 32'h1F, 0, 1, 4'b0100, 4'b0100);
    add(4'b1111, 32'h1F, 1, 0, 4'b0000, 4'b0000);
    add(4'b1111, 32'h1F, 0, 0, 4'b0000, 4'b0000);
    add(4'b1111, 32'h1F, 0, 0, 4'b0000, 4'b0000);

    reset = 1'b0; irq_in = '0; int_en = '0; Iack = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_ireq", 32'(Ireq), 32'd0);
    check("reset_gnt", 32'(gntInt), 32'd0);
    check("reset_pend", 32'(pending_o), 32'd0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].irq, vecs[i].en, vecs[i].ack);
      check($sformatf("vec%0d_ireq", i), 32'(Ireq), 32'(vecs[i].ireq));
      check($sformatf("vec%0d_gnt", i), 32'(gntInt), 32'(vecs[i].gnt));
      check($sformatf("vec%0d_pend", i), 32'(pending_o), 32'(vecs[i].pend));
    end

    // asynchronous reset while requesting, then a line held high through release
    repeat (3) step(4'b0000, 32'h1F, 0);
    step(4'b0001, 32'h1F, 0);
    step(4'b0001, 32'h1F, 0);
    check("pre_reset_ireq", 32'(Ireq), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("async_ireq", 32'(Ireq), 32'd0);
    check("async_gnt", 32'(gntInt), 32'd0);
    check("async_pend", 32'(pending_o), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    n_req = 0;
    prev_ireq = 1'b0;
    for (int k = 0; k < 14; k++) begin
      step(4'b0001, 32'h1F, Ireq);
      if (Ireq && !prev_ireq) n_req++;
      prev_ireq = Ireq;
    end
    check("held_line_requests", 32'(n_req), 32'd1);

    // randomized traffic against the model
    irq_r = '0;
    en_r = 32'h1F;
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(7) == 0) irq_r[b] = ~irq_r[b];
      if ($urandom_range(39) == 0)
        en_r = ($urandom_range(9) < 6) ? 32'h1F : 32'($urandom);
      step(irq_r, en_r, $urandom_range(99) < 35);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/int_arbiter.md
# int_arbiter

Interrupt arbiter at the device end of the CPU interrupt handshake: it collects four edge-triggered device interrupt lines, applies the CPU-supplied enable word, and presents one granted source at a time to the multi-cycle CPU on `Ireq`/`gntInt`. It holds the request until the CPU answers with `Iack`, then retires the granted source. It sits between the peripheral interrupt lines and the CPU top, driving the CPU's `Ireq` and `gntInt` inputs and consuming its `Iack` and `intrrupt_en_o` outputs.

## Interface
- `HOLDOFF`, 2: idle cycles forced after each `Iack` before the next request may be raised (1..15).
- `clk` input 1: system clock; all state changes on rising edge.
- `reset` input 1: asynchronous, active-low reset (asserted at 0).
- `irq_in` input 4: device interrupt lines; rising edge = one event; bit 0 highest priority.
- `int_en` input 32: CPU interrupt enable word. Bit 0 is the global enable; bits [4:1] are per-source masks for `irq_in[3:0]`; bits [31:5] are ignored.
- `Iack` input 1: CPU acknowledge; one-cycle pulse when the CPU takes the interrupt.
- `Ireq` output 1: interrupt request to the CPU.
- `gntInt` output 4: one-hot granted source; nonzero only while `Ireq`=1.
- `pending_o` output 4: latched pending events, for status readback.

## Operation
- Edge detect: `irq_prev` is a register of `irq_in`. `rise = irq_in & ~irq_prev`. `irq_prev` resets to 0, so a line that is high when reset releases counts as one event.
- Pending: the `pending` bit for a source is set on `rise`. It is cleared only when that source is granted and `Iack` is sampled high. If a rise and the clear occur in the same cycle for the same bit, the set wins. Multiple edges while a bit is pending collapse into a single event.
- Eligible: `elig = pending & int_en[4:1] & {4{int_en[0]}}`.
- State machine (IDLE, REQ, HOLD), reset state IDLE:
  - IDLE: if `elig` != 0, latch `gnt` = lowest-index set bit of `elig`, set `Ireq`=1, go to REQ. Otherwise stay in IDLE.
  - REQ: `Ireq` and `gntInt` are held stable, with no preemption by higher-priority arrivals.
    - If `Iack`=1: clear `pending[gnt]`, drive `Ireq`=0 and `gntInt`=0, load the holdoff counter with `HOLDOFF`-1, go to HOLD.
    - Else if the granted source is no longer eligible (mask or global enable dropped): withdraw. Drive `Ireq`=0 and `gntInt`=0, keep the pending bit, go to IDLE.
    - `Iack` takes priority over withdrawal when both occur in the same cycle.
  - HOLD: decrement the counter each cycle; go to IDLE when the counter reaches 0. `Iack` is ignored in this state.
- `Iack` in IDLE is ignored (spurious); it changes no state.
- `gntInt` = `Ireq` ? `gnt` : 0, driven from registers with no combinational path from inputs.
- Reset mid-operation: all state is cleared immediately and asynchronously, and pending events are lost.

## Timing
- Reset values: `Ireq`=0, `gntInt`=0, `pending_o`=0, state=IDLE, holdoff counter=0, `irq_prev`=0.
- Latency:
  - Rise sampled at edge e0 → `pending_o` set after e0.
  - `Ireq`/`gntInt` asserted after e1 (2 edges), provided the source is enabled and the arbiter is idle.
- `Iack` sampled at edge a0 → `Ireq`=0 and the pending bit cleared after a0.
- The earliest next `Ireq` is after edge a0+`HOLDOFF`+1.
- The CPU registers `gntInt & Ireq` one cycle later; the grant is guaranteed stable for every cycle `Ireq` is high.
- Minimum `Ireq` pulse is 1 cycle (an ack in the first REQ cycle is legal).

## Test plan
- Single event, `int_en`=0x0000_001F: `irq_in[2]` rises → `pending_o`=0100 after 1 edge. `Ireq`=1 and `gntInt`=0100 after 2 edges. `Iack` pulse → `Ireq`=0 and `pending_o`=0000 the next cycle.
- Priority and no-preempt: `irq_in[3]` rises, `Ireq` asserts with `gntInt`=1000. Then `irq_in[0]` rises: `gntInt` stays 1000 until `Iack`. After `HOLDOFF`=2 idle cycles, `gntInt`=0001.
- Masking: `int_en`=0x0000_0011 (global enabled, only source 3 enabled), `irq_in`=1111 → only `gntInt`=1000 is granted, and `pending_o` remains 0111 after the ack. Clearing `int_en[0]` while in REQ → `Ireq` drops with no ack, and the pending bit is retained.
- Collision: a new `irq_in[1]` rise in the same cycle as `Iack` for source 1 → `pending_o[1]` remains 1 and a second request follows after holdoff. A spurious `Iack` in IDLE → no change.
- Reset: assert `reset`=0 asynchronously mid-REQ → `Ireq`, `gntInt` and `pending_o` go to 0 without waiting for a clock edge. An `irq_in` line held high through reset release produces exactly one request.
